// File: rtl/jk_excite_gen_311_if.sv
// jk_excite_gen_311_if: control, feedback and excitation signals between
// the excitation generator and the upstream controller / JK bank.
interface jk_excite_gen_311_if #(
    parameter int WIDTH = 4
);
    logic             en_311;
    logic             up_311;
    logic             load_311;
    logic [WIDTH-1:0] load_val_311;
    logic [WIDTH-1:0] q_fb_311;
    logic [WIDTH-1:0] j_311;
    logic [WIDTH-1:0] k_311;
    logic             clr_311;
    logic             tc_311;
    logic             err_311;

    modport master (
        output en_311, up_311, load_311, load_val_311, q_fb_311,
        input  j_311, k_311, clr_311, tc_311, err_311
    );

    modport slave (
        input  en_311, up_311, load_311, load_val_311, q_fb_311,
        output j_311, k_311, clr_311, tc_311, err_311
    );
endinterface

// File: rtl/jk_excite_gen_311.sv
// jk_excite_gen_311: mod-MODULUS up/down counter realised as per-bit
// J/K excitation for a negedge-clocked JK flip-flop bank.
module jk_excite_gen_311 #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic                clk_311,
    input logic                reset,
    jk_excite_gen_311_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

    typedef enum logic [1:0] {INIT, IDLE, RUN} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic             clr_q;
    logic             tc_q;
    logic             err_q;
    logic             skip_q;

    logic [WIDTH-1:0] nxt_d;
    logic             go_d;
    logic             tc_d;
    logic             mis_d;

    // Wrap is explicit at both ends; loads above range saturate.
    always_comb begin
        nxt_d = exp_q;
        if (bus.load_311) begin
            if ({1'b0, bus.load_val_311} >= MOD_V) begin
                nxt_d = MAX_V;
            end else begin
                nxt_d = bus.load_val_311;
            end
        end else if (bus.en_311 && bus.up_311) begin
            nxt_d = (exp_q == MAX_V) ? '0 : exp_q + ONE_V;
        end else if (bus.en_311) begin
            nxt_d = (exp_q == '0) ? MAX_V : exp_q - ONE_V;
        end
    end

    assign go_d  = bus.en_311 | bus.load_311;
    assign tc_d  = bus.up_311 ? (nxt_d == MAX_V) : (nxt_d == '0);
    assign mis_d = !skip_q && (bus.q_fb_311 != exp_q);

    always_ff @(posedge clk_311 or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            exp_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            clr_q   <= 1'b1;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    state_q <= IDLE;
                    clr_q   <= 1'b0;
                    exp_q   <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    tc_q    <= 1'b0;
                    // Bank was cleared on the negedge just passed; skip one check.
                    skip_q  <= 1'b1;
                end
                IDLE, RUN: begin
                    skip_q <= 1'b0;
                    err_q  <= err_q | mis_d;
                    if (go_d) begin
                        state_q <= RUN;
                        j_q     <= nxt_d & ~exp_q;
                        k_q     <= exp_q & ~nxt_d;
                        exp_q   <= nxt_d;
                        tc_q    <= tc_d;
                    end else begin
                        state_q <= IDLE;
                        j_q     <= '0;
                        k_q     <= '0;
                        tc_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign bus.j_311   = j_q;
    assign bus.k_311   = k_q;
    assign bus.clr_311 = clr_q;
    assign bus.tc_311  = tc_q;
    assign bus.err_311 = err_q;
endmodule

// File: tb/tb_jk_excite_gen_311.sv
// tb_jk_excite_gen_311: drives jk_excite_gen_311 against a behavioural
// JK bank and a modular-arithmetic counter model.
module tb_jk_excite_gen_311;
    localparam int MOD = 10;

    logic       clk;
    logic       rst_n;
    logic [3:0] bank_q;
    logic [3:0] fault_mask;

    int n_checks;
    int n_errors;
    int mexp;
    bit m_init;
    bit m_skip;
    bit m_err;

    jk_excite_gen_311_if #(.WIDTH(4)) bus ();

    jk_excite_gen_311 #(.WIDTH(4), .MODULUS(MOD)) dut (
        .clk_311(clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK flip-flop bank: negedge clocked, clear wins.
    always @(negedge clk) begin
        if (bus.clr_311) begin
            bank_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({bus.j_311[i], bus.k_311[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    assign bus.q_fb_311 = bank_q & ~fault_mask;

    function automatic logic [10:0] obs();
        return {bus.j_311, bus.k_311, bus.clr_311, bus.tc_311, bus.err_311};
    endfunction

    task automatic set_in(bit en, bit up, bit ld, int lv);
        bus.en_311       = en;
        bus.up_311       = up;
        bus.load_311     = ld;
        bus.load_val_311 = 4'(lv);
    endtask

    // Predict {j,k,clr,tc,err} after the next posedge, then advance.
    task automatic step(output logic [10:0] e);
        int         nxt;
        logic       etc;
        logic [3:0] x4;
        logic [3:0] n4;
        nxt = mexp;
        etc = 1'b0;
        if (!m_init && !m_skip && ((4'(mexp) & fault_mask) != 4'b0000)) m_err = 1'b1;
        if (!m_init && (bus.load_311 || bus.en_311)) begin
            if (bus.load_311) begin
                nxt = (int'(bus.load_val_311) >= MOD) ? MOD - 1 : int'(bus.load_val_311);
            end else if (bus.up_311) begin
                nxt = (mexp + 1) % MOD;
            end else begin
                nxt = (mexp + MOD - 1) % MOD;
            end
            etc = bus.up_311 ? (nxt == MOD - 1) : (nxt == 0);
        end
        x4 = 4'(mexp);
        n4 = 4'(nxt);
        e = {n4 & ~x4, x4 & ~n4, 1'b0, etc, m_err};
        m_skip = m_init;
        m_init = 1'b0;
        @(posedge clk);
        #1;
        mexp = nxt;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fault_mask = 4'b0000;
        set_in(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        mexp   = 0;
        m_init = 1'b1;
        m_skip = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        do_reset();
        n_checks++;
        if (obs() !== 11'b0000_0000_100) begin
            n_errors++;
            $display("FAIL reset_out: got %b expected %b", obs(), 11'b0000_0000_100);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bank_q !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_bank: got %b expected 0000", bank_q);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL reset_release[%0d]: got %b expected %b", i, obs(), e);
            end
        end
        n_checks++;
        if (bus.q_fb_311 !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_qfb: got %b expected 0000", bus.q_fb_311);
        end
    endtask

    task automatic test_count_up();
        logic [10:0] e;
        int          pre;
        set_in(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            pre = mexp;
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL count_up[%0d]: got %b expected %b", i, obs(), e);
            end
            if (pre == 7) begin
                n_checks++;
                if ({bus.j_311, bus.k_311} !== 8'b1000_0111) begin
                    n_errors++;
                    $display("FAIL up_7_to_8: got %b expected 10000111", {bus.j_311, bus.k_311});
                end
            end
            if (pre == 9) begin
                n_checks++;
                if ({bus.j_311, bus.k_311, bus.tc_311} !== 9'b0000_1001_0) begin
                    n_errors++;
                    $display("FAIL up_9_to_0: got %b expected 000010010", {bus.j_311, bus.k_311, bus.tc_311});
                end
            end
        end
    endtask

    task automatic test_count_down();
        logic [10:0] e;
        int          pre;
        set_in(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            pre = mexp;
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL count_down[%0d]: got %b expected %b", i, obs(), e);
            end
            if (pre == 0) begin
                n_checks++;
                if ({bus.j_311, bus.k_311} !== 8'b1001_0000) begin
                    n_errors++;
                    $display("FAIL down_0_to_9: got %b expected 10010000", {bus.j_311, bus.k_311});
                end
            end
        end
    endtask

    task automatic test_load();
        logic [10:0] e;
        set_in(1, 1, 1, 7);
        step(e);
        n_checks++;
        if (obs() !== e || mexp != 7) begin
            n_errors++;
            $display("FAIL load_7: got %b expected %b", obs(), e);
        end
        set_in(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL load_resume[%0d]: got %b expected %b", i, obs(), e);
            end
        end
        set_in(0, 1, 1, 12);
        step(e);
        n_checks++;
        if (obs() !== e || bus.tc_311 !== 1'b1) begin
            n_errors++;
            $display("FAIL load_sat: got %b expected %b", obs(), e);
        end
        set_in(0, 1, 0, 0);
        repeat (2) begin
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL idle_hold: got %b expected %b", obs(), e);
            end
        end
        n_checks++;
        if (bus.q_fb_311 !== 4'd9) begin
            n_errors++;
            $display("FAIL idle_bank: got %0d expected 9", bus.q_fb_311);
        end
    endtask

    task automatic test_random();
        logic [10:0] e;
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL random[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_fault();
        logic [10:0] e;
        set_in(0, 1, 1, 4);
        step(e);
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL fault_setup: got %b expected %b", obs(), e);
        end
        fault_mask = 4'b0100;
        set_in(1, 1, 0, 0);
        step(e);
        fault_mask = 4'b0000;
        n_checks++;
        if (obs() !== e || bus.err_311 !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_detect: got %b expected %b", obs(), e);
        end
        for (int i = 0; i < 8; i++) begin
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL fault_sticky[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] e;
        test_reset();
        set_in(1, 1, 1, 6);
        step(e);
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL midrst_setup: got %b expected %b", obs(), e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 11'b0000_0000_100) begin
            n_errors++;
            $display("FAIL midrst_async: got %b expected %b", obs(), 11'b0000_0000_100);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bank_q !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst_bank: got %b expected 0000", bank_q);
        end
        test_reset();
        set_in(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(e);
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL midrst_restart[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bank_q     = 4'b0000;
        fault_mask = 4'b0000;
        rst_n      = 1'b0;
        set_in(0, 0, 0, 0);
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_random();
        test_fault();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
